rvm_scu_arb: RTL and testbench

- Arbitrates the SCU CSR-access port between two requesters: the core execute path (CSR instructions) and a debug CSR access port.
- Sequences each access as one SCU issue cycle, captures the SCU read data and returns it with a done pulse.
- Sits between the decode/execute control and the SCU's scu_op, arg_rs1_addr, arg_rs1, arg_imm and wb_val signals.

---
 rtl/rvm_scu_arb.sv | 74 +++++++
 tb/tb_rvm_scu_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rvm_scu_arb.sv
// rvm_scu_arb: arbitrates core and debug CSR accesses onto the SCU port and returns the old CSR value.
module rvm_scu_arb #(
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_stall,
  input  logic        core_req,
  input  logic [3:0]  core_op,
  input  logic [4:0]  core_rs1_addr,
  input  logic [31:0] core_rs1,
  input  logic [11:0] core_csr_addr,
  output logic        core_gnt,
  output logic        core_done,
  output logic [31:0] core_rdata,
  input  logic        dbg_req,
  input  logic        dbg_write,
  input  logic [11:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic [3:0]  scu_op,
  output logic [4:0]  scu_rs1_addr,
  output logic [31:0] scu_rs1,
  output logic [31:0] scu_imm,
  input  logic [31:0] scu_wb_val
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ISSUE_CORE = 3'd1;
  localparam logic [2:0] RESP_CORE  = 3'd2;
  localparam logic [2:0] ISSUE_DBG  = 3'd3;
  localparam logic [2:0] RESP_DBG   = 3'd4;
  localparam logic [3:0] CSRRW      = 4'b0001;
  localparam logic [3:0] CSRRS      = 4'b0010;
  localparam logic [3:0] MAX_WAIT   = 4'(DBG_MAX_WAIT);
  logic [2:0] state, state_nxt;
  logic [3:0] wait_cnt;
  logic       arb, dbg_win;
  assign arb     = (state == IDLE) && !core_stall && (core_req || dbg_req);
  assign dbg_win = dbg_req && (!core_req || wait_cnt == MAX_WAIT);
  always_comb begin
    state_nxt = (state == IDLE)       ? (arb ? (dbg_win ? ISSUE_DBG : ISSUE_CORE) : IDLE) :
                (state == ISSUE_CORE) ? RESP_CORE :
                (state == ISSUE_DBG)  ? RESP_DBG  : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      core_rdata <= 32'd0;
      dbg_rdata  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (!dbg_req || (arb && dbg_win))
        wait_cnt <= 4'd0;
      else if (arb && wait_cnt != MAX_WAIT)
        wait_cnt <= wait_cnt + 4'd1;
      if (state == ISSUE_CORE)
        core_rdata <= scu_wb_val;
      if (state == ISSUE_DBG)
        dbg_rdata <= scu_wb_val;
    end
  end
  assign core_gnt  = state == ISSUE_CORE;
  assign dbg_gnt   = state == ISSUE_DBG;
  assign core_done = state == RESP_CORE;
  assign dbg_done  = state == RESP_DBG;
  // debug reads go out as CSRRS with a zero mask so the CSR is rewritten unchanged
  assign scu_op       = core_gnt ? core_op : dbg_gnt ? (dbg_write ? CSRRW : CSRRS) : 4'b0000;
  assign scu_rs1_addr = core_gnt ? core_rs1_addr : 5'd0;
  assign scu_rs1      = core_gnt ? core_rs1 : (dbg_gnt && dbg_write) ? dbg_wdata : 32'd0;
  assign scu_imm      = {20'd0, core_gnt ? core_csr_addr : dbg_gnt ? dbg_addr : 12'd0};
endmodule

// File: tb/tb_rvm_scu_arb.sv
// tb_rvm_scu_arb: directed stimulus against a cycle-level arbitration model and a CSR-file SCU stand-in.
module tb_rvm_scu_arb;
  localparam int MAXW = 4;
  logic clk = 0, reset = 1;
  logic core_stall = 0, core_req = 0, dbg_req = 0, dbg_write = 0;
  logic [3:0] core_op = 0;
  logic [4:0] core_rs1_addr = 0;
  logic [31:0] core_rs1 = 0, dbg_wdata = 0;
  logic [11:0] core_csr_addr = 0, dbg_addr = 0;
  logic core_gnt, core_done, dbg_gnt, dbg_done;
  logic [31:0] core_rdata, dbg_rdata, scu_rs1, scu_imm, scu_wb_val;
  logic [3:0] scu_op;
  logic [4:0] scu_rs1_addr;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  rvm_scu_arb #(.DBG_MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .core_stall(core_stall), .core_req(core_req), .core_op(core_op),
    .core_rs1_addr(core_rs1_addr), .core_rs1(core_rs1), .core_csr_addr(core_csr_addr),
    .core_gnt(core_gnt), .core_done(core_done), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .scu_op(scu_op), .scu_rs1_addr(scu_rs1_addr), .scu_rs1(scu_rs1), .scu_imm(scu_imm),
    .scu_wb_val(scu_wb_val));
  // SCU stand-in: a CSR file that is never reset, so writes survive an arbiter reset
  logic [31:0] csr [0:4095];
  logic booted = 0;
  logic op_ok;
  assign op_ok = scu_op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
  always_comb scu_wb_val = op_ok ? csr[scu_imm[11:0]] : 32'd0;
  always @(posedge clk) begin
    booted <= 1;
    if (!booted) begin
      for (int i = 0; i < 4096; i++) csr[i] <= 0;
    end else if (op_ok) begin
      case (scu_op)
        4'd1: csr[scu_imm[11:0]] <= scu_rs1;
        4'd2: csr[scu_imm[11:0]] <= scu_wb_val | scu_rs1;
        4'd3: csr[scu_imm[11:0]] <= scu_wb_val & ~scu_rs1;
        4'd5: csr[scu_imm[11:0]] <= {27'd0, scu_rs1_addr};
        4'd6: csr[scu_imm[11:0]] <= scu_wb_val | {27'd0, scu_rs1_addr};
        default: csr[scu_imm[11:0]] <= scu_wb_val & ~{27'd0, scu_rs1_addr};
      endcase
    end
  end
  // model: phase counts down cycles left in an access (2 = issue, 1 = response), losses = debug losses
  int m_phase = 0, m_losses = 0;
  logic m_dbg = 0, started = 0;
  logic [31:0] m_crd = 0, m_drd = 0;
  logic m_arb, m_dwin;
  assign m_arb  = m_phase == 0 && !core_stall && (core_req || dbg_req);
  assign m_dwin = dbg_req && (!core_req || m_losses >= MAXW);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    started <= 1;
    if (reset) begin
      m_phase <= 0; m_losses <= 0; m_crd <= 0; m_drd <= 0;
    end else begin
      if (m_arb) begin
        m_phase <= 2; m_dbg <= m_dwin;
      end else if (m_phase > 0) m_phase <= m_phase - 1;
      if (m_phase == 2 && m_dbg) m_drd <= scu_wb_val;
      if (m_phase == 2 && !m_dbg) m_crd <= scu_wb_val;
      if (!dbg_req) m_losses <= 0;
      else if (m_arb) m_losses <= m_dwin ? 0 : (m_losses < MAXW ? m_losses + 1 : m_losses);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (started) begin
      logic ci, di;
      ci = m_phase == 2 && !m_dbg;
      di = m_phase == 2 && m_dbg;
      chk("core_gnt", 32'(core_gnt), 32'(ci));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(di));
      chk("core_done", 32'(core_done), 32'(m_phase == 1 && !m_dbg));
      chk("dbg_done", 32'(dbg_done), 32'(m_phase == 1 && m_dbg));
      chk("core_rdata", core_rdata, m_crd);
      chk("dbg_rdata", dbg_rdata, m_drd);
      chk("scu_op", 32'(scu_op), ci ? 32'(core_op) : di ? (dbg_write ? 32'd1 : 32'd2) : 32'd0);
      chk("scu_rs1_addr", 32'(scu_rs1_addr), ci ? 32'(core_rs1_addr) : 32'd0);
      chk("scu_rs1", scu_rs1, ci ? core_rs1 : (di && dbg_write) ? dbg_wdata : 32'd0);
      chk("scu_imm", scu_imm, ci ? 32'(core_csr_addr) : di ? 32'(dbg_addr) : 32'd0);
    end
  end
  task automatic core_acc(input logic [3:0] op, input logic [4:0] ra, input logic [31:0] rs,
                          input logic [11:0] a, output logic [31:0] rd, output int lat,
                          output logic [4:0] ra_seen);
    @(posedge clk); #1;
    core_req = 1; core_op = op; core_rs1_addr = ra; core_rs1 = rs; core_csr_addr = a;
    lat = -1; ra_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (core_gnt) begin lat = n; ra_seen = scu_rs1_addr; break; end
    end
    if (lat < 0) chk("core_gnt_timeout", 0, 1);
    @(posedge clk); #1 core_req = 0;
    @(negedge clk); rd = core_rdata;
    chk("core_done_pulse", 32'(core_done), 1);
  endtask
  task automatic dbg_acc(input logic w, input logic [11:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [3:0] op_seen, output logic [31:0] rs_seen);
    int lat;
    @(posedge clk); #1;
    dbg_req = 1; dbg_write = w; dbg_addr = a; dbg_wdata = wd;
    lat = -1; op_seen = 0; rs_seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dbg_gnt) begin lat = n; op_seen = scu_op; rs_seen = scu_rs1; break; end
    end
    if (lat < 0) chk("dbg_gnt_timeout", 0, 1);
    @(posedge clk); #1 dbg_req = 0;
    @(negedge clk); rd = dbg_rdata;
    chk("dbg_done_pulse", 32'(dbg_done), 1);
  endtask
  task automatic grant_seq(output logic [5:0] seq);
    int k = 0;
    seq = 0;
    for (int n = 0; n < 60 && k < 6; n++) begin
      @(negedge clk);
      if (core_gnt || dbg_gnt) begin seq[k] = dbg_gnt; k++; end
    end
    if (k < 6) chk("grant_seq_timeout", 32'(k), 6);
  endtask
  initial begin
    logic [31:0] rd, rs;
    logic [3:0] op;
    logic [4:0] ra;
    logic [5:0] seq;
    int lat, g;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset_scu_op", 32'(scu_op), 0);
    chk("reset_core_rdata", core_rdata, 0);
    core_acc(4'd1, 5'd0, 32'hDEADBEEF, 12'h340, rd, lat, ra);
    chk("csrrw_lat", 32'(lat), 1);
    chk("csrrw_old", rd, 0);
    core_acc(4'd2, 5'd0, 32'd0, 12'h340, rd, lat, ra);
    chk("csrrs_read", rd, 32'hDEADBEEF);
    core_acc(4'd1, 5'd0, 32'd0, 12'h340, rd, lat, ra);
    dbg_acc(1'b1, 12'h340, 32'h12345678, rd, op, rs);
    chk("dbg_write_old", rd, 0);
    chk("dbg_write_op", 32'(op), 1);
    dbg_acc(1'b0, 12'h340, 32'hFFFFFFFF, rd, op, rs);
    chk("dbg_read_val", rd, 32'h12345678);
    chk("dbg_read_op", 32'(op), 2);
    chk("dbg_read_rs1", rs, 0);
    core_acc(4'd1, 5'd0, 32'h888, 12'h304, rd, lat, ra);
    core_acc(4'd6, 5'b00011, 32'hFFFF0000, 12'h304, rd, lat, ra);
    chk("csrrsi_rs1_addr", 32'(ra), 3);
    chk("csrrsi_old_mie", rd, 32'h888);
    core_acc(4'd15, 5'd7, 32'hFFFFFFFF, 12'h304, rd, lat, ra);
    chk("invalid_op_rdata", rd, 0);
    dbg_acc(1'b0, 12'h304, 32'd0, rd, op, rs);
    chk("mie_after", rd, 32'h88B);
    @(posedge clk); #1;
    core_stall = 1; core_req = 1; dbg_req = 1;
    core_op = 4'd2; core_rs1_addr = 0; core_rs1 = 0; core_csr_addr = 12'h340;
    dbg_write = 0; dbg_addr = 12'h340;
    g = 0;
    repeat (10) begin @(negedge clk); g += int'(core_gnt) + int'(dbg_gnt); end
    chk("stall_no_gnt", 32'(g), 0);
    @(posedge clk); #1 core_stall = 0;
    grant_seq(seq);
    chk("fairness_seq", 32'(seq), 32'b010000);
    @(posedge clk); #1 core_req = 0; dbg_req = 0;
    repeat (3) @(posedge clk);
    #1 dbg_req = 1; dbg_write = 1; dbg_addr = 12'h340; dbg_wdata = 32'hAAAA5555;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dbg_gnt) begin lat = n; break; end
    end
    if (lat < 0) chk("rst_dbg_gnt_timeout", 0, 1);
    reset = 1; dbg_req = 0;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rst_no_dbg_done", 32'(dbg_done), 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_scu_op", 32'(scu_op), 0);
    dbg_acc(1'b0, 12'h340, 32'd0, rd, op, rs);
    chk("rst_write_landed", rd, 32'hAAAA5555);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
